// File: rtl/rot_coord_gen.sv
// Rotated, patch-centred sample coordinate generator for the SIFT descriptor stage.
// Scans a PATCH x PATCH window in raster order and emits one (u,v,row,col) beat per transfer.
module rot_coord_gen #(
  parameter int PATCH     = 16,
  parameter int NUM_DIR   = 16,
  parameter int COEF_FRAC = 10,
  parameter int OUT_FRAC  = 0,
  parameter int OUT_W     = 5,
  localparam int ROW_W    = $clog2(PATCH),
  localparam int COL_W    = $clog2(PATCH),
  localparam int DIR_W    = $clog2(NUM_DIR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIR_W-1:0]        dir,
  input  logic                    abort,
  output logic                    busy,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [OUT_W-1:0] o_u,
  output logic signed [OUT_W-1:0] o_v,
  output logic [ROW_W-1:0]        o_row,
  output logic [COL_W-1:0]        o_col,
  output logic                    o_last,
  output logic                    done
);

  localparam int  SH    = COEF_FRAC + 1 - OUT_FRAC;
  localparam int  CW    = COEF_FRAC + 2;
  localparam int  ACC_W = ROW_W + COEF_FRAC + 3;
  localparam real PI    = 3.14159265358979323846;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(PATCH - 1);
  localparam logic signed [ACC_W:0]   RND  = (ACC_W+1)'(2 ** (SH - 1));
  localparam logic signed [ACC_W:0]   OMAX = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W:0]   OMIN = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                  state, state_next;
  logic [DIR_W-1:0]        dir_q;
  logic [DIR_W-1:0]        dir_ok;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic signed [ACC_W-1:0] acc_u, acc_v, row_u, row_v;
  logic signed [ACC_W-1:0] c_ext, s_ext, init_u, init_v;
  logic signed [CW-1:0]    cos_tab [NUM_DIR];
  logic signed [CW-1:0]    sin_tab [NUM_DIR];
  logic                    xfer, at_last, done_q, accept;

  // Coefficients are rounded half away from zero at elaboration time.
  for (genvar k = 0; k < NUM_DIR; k++) begin : g_coef
    localparam real ANG = 2.0 * PI * k / NUM_DIR;
    localparam real CR  = $cos(ANG) * (2.0 ** COEF_FRAC);
    localparam real SR  = $sin(ANG) * (2.0 ** COEF_FRAC);
    localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
    localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
    assign cos_tab[k] = CW'(CI);
    assign sin_tab[k] = CW'(SI);
  end

  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] q;
    biased = (ACC_W+1)'(a) + RND;
    q      = biased >>> SH;
    if (q > OMAX)      return OMAX[OUT_W-1:0];
    else if (q < OMIN) return OMIN[OUT_W-1:0];
    else               return q[OUT_W-1:0];
  endfunction

  assign dir_ok  = (int'(dir) >= NUM_DIR) ? '0 : dir;
  assign accept  = (state == IDLE) && start && !abort;
  assign at_last = (row == ROW_W'(PATCH - 1)) && (col == COL_W'(PATCH - 1));
  assign xfer    = (state == RUN) && o_ready && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = abort ? IDLE : RUN;
      RUN:     if (abort || (xfer && at_last)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    o_valid = (state == RUN);
    o_last  = o_valid && at_last;
    o_u     = o_valid ? round_sat(acc_u) : '0;
    o_v     = o_valid ? round_sat(acc_v) : '0;
    o_row   = o_valid ? row : '0;
    o_col   = o_valid ? col : '0;
    done    = done_q;
  end

  // Accumulator values at (r,c) = (0,0), i.e. x2 = y2 = -(PATCH-1).
  always_comb begin
    c_ext  = ACC_W'(cos_tab[dir_q]);
    s_ext  = ACC_W'(sin_tab[dir_q]);
    init_u = -(HALF * (c_ext + s_ext));
    init_v = -(HALF * (c_ext - s_ext));
  end

  // Column steps move x2 by +2; row steps restart from the saved row-start value with y2 +2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q  <= '0;
      row    <= '0;
      col    <= '0;
      acc_u  <= '0;
      acc_v  <= '0;
      row_u  <= '0;
      row_v  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= xfer && at_last;
      if (accept) dir_q <= dir_ok;
      if (state == LOAD) begin
        acc_u <= init_u;
        acc_v <= init_v;
        row_u <= init_u;
        row_v <= init_v;
        row   <= '0;
        col   <= '0;
      end else if (xfer && !at_last) begin
        if (col == COL_W'(PATCH - 1)) begin
          col   <= '0;
          row   <= row + 1'b1;
          acc_u <= row_u + (s_ext <<< 1);
          acc_v <= row_v + (c_ext <<< 1);
          row_u <= row_u + (s_ext <<< 1);
          row_v <= row_v + (c_ext <<< 1);
        end else begin
          col   <= col + 1'b1;
          acc_u <= acc_u + (c_ext <<< 1);
          acc_v <= acc_v - (s_ext <<< 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rot_coord_gen.sv
// Randomised bench for rot_coord_gen: every beat is compared against the direct rotation formula.
// A second instance with OUT_W=4 exercises output saturation under the same stimulus.
module tb_rot_coord_gen;

  localparam real PI = 3.14159265358979323846;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        dir;
  logic              abort;
  logic              o_ready;
  logic              busy, o_valid, o_last, done;
  logic signed [4:0] o_u, o_v;
  logic [3:0]        o_row, o_col;
  logic              busy4, valid4, last4, done4;
  logic signed [3:0] u4, v4;
  logic [3:0]        row4, col4;

  int checks   = 0;
  int failures = 0;

  rot_coord_gen dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .busy(busy), .o_valid(o_valid), .o_ready(o_ready),
    .o_u(o_u), .o_v(o_v), .o_row(o_row), .o_col(o_col),
    .o_last(o_last), .done(done)
  );

  rot_coord_gen #(.OUT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .busy(busy4), .o_valid(valid4), .o_ready(o_ready),
    .o_u(u4), .o_v(v4), .o_row(row4), .o_col(col4),
    .o_last(last4), .done(done4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int coef(input int d, input bit is_sin);
    real a, x;
    a = 2.0 * PI * d / 16.0;
    x = (is_sin ? $sin(a) : $cos(a)) * 1024.0;
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // Direct formula: rotate centred doubled coordinates, round half up, saturate to w bits.
  function automatic int model_uv(input int d, input int r, input int c, input int w, input bit is_v);
    int x2, y2, cc, ss, a, q, hi, lo;
    x2 = 2 * c - 15;
    y2 = 2 * r - 15;
    cc = coef(d, 1'b0);
    ss = coef(d, 1'b1);
    a  = is_v ? (y2 * cc - x2 * ss) : (x2 * cc + y2 * ss);
    q  = (a + 1024) >>> 11;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic check_beat(input int d, input int idx);
    int r, c;
    r = idx / 16;
    c = idx % 16;
    check_output("row",   int'(o_row), r);
    check_output("col",   int'(o_col), c);
    check_output("u",     int'(o_u), model_uv(d, r, c, 5, 1'b0));
    check_output("v",     int'(o_v), model_uv(d, r, c, 5, 1'b1));
    check_output("last",  int'(o_last), (idx == 255) ? 1 : 0);
    check_output("u_w4",  int'(u4), model_uv(d, r, c, 4, 1'b0));
    check_output("v_w4",  int'(v4), model_uv(d, r, c, 4, 1'b1));
    check_output("pos_w4", int'({valid4, last4, row4, col4}), 512 + ((idx == 255) ? 256 : 0) + idx);
  endtask

  // One scan: pre_started means start was already driven on this negedge (back-to-back).
  // abort_at / start_at / rst_at trigger events at that beat index (-1 disables).
  task automatic apply_stimulus(input int d, input int ready_pct, input int abort_at,
                                input int start_at, input int rst_at,
                                input bit pre_started, input int next_dir);
    int idx, cyc;
    bit ended, completed;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
      dir   = 4'(d);
    end
    @(negedge clk);
    start = 1'b0;
    check_output("load_valid", int'(o_valid), 0);
    check_output("load_busy",  int'(busy), 1);
    idx = 0; cyc = 0; ended = 1'b0; completed = 1'b0;
    while (!ended) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      cyc++;
      if (cyc > 3000) begin
        check_output("timeout", 0, 1);
        ended = 1'b1;
      end else if (!o_valid) begin
        check_output("run_valid", int'(o_valid), 1);
        ended = 1'b1;
      end else begin
        check_beat(d, idx);
        if (idx == abort_at) begin
          abort   = 1'b1;
          o_ready = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check_output("abort_valid", int'(o_valid), 0);
          check_output("abort_busy",  int'(busy), 0);
          check_output("abort_done",  int'(done), 0);
          @(negedge clk);
          check_output("abort_done_late", int'(done), 0);
          ended = 1'b1;
        end else if (idx == rst_at) begin
          rst = 1'b1;
          #1;
          check_output("rst_outputs",
                       int'({o_valid, busy, o_u, o_v, o_row, o_col, o_last, done}), 0);
          check_output("rst_outputs_w4", int'({valid4, busy4, u4, v4, row4, col4, last4, done4}), 0);
          @(negedge clk);
          rst     = 1'b0;
          o_ready = 1'b0;
          ended   = 1'b1;
        end else begin
          o_ready = ($urandom_range(99) < ready_pct);
          if (idx == start_at) begin
            start = 1'b1;
            dir   = 4'(d + 5);
          end
          if (o_ready) begin
            idx++;
            if (idx == 256) begin
              ended     = 1'b1;
              completed = 1'b1;
            end
          end
        end
      end
    end
    if (completed) begin
      @(negedge clk);
      check_output("done_pulse", int'(done), 1);
      check_output("done_w4",    int'(done4), 1);
      check_output("end_busy",   int'(busy), 0);
      check_output("end_valid",  int'(o_valid), 0);
      if (next_dir >= 0) begin
        start = 1'b1;
        dir   = 4'(next_dir);
      end else begin
        @(negedge clk);
        check_output("done_single", int'(done), 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; o_ready = 1'b0; dir = '0;
    repeat (2) @(negedge clk);
    check_output("reset_outputs", int'({o_valid, busy, o_u, o_v, o_row, o_col, o_last, done}), 0);
    rst = 1'b0;

    $display("[TB] dir 0, full throughput");
    apply_stimulus(0, 100, -1, -1, -1, 1'b0, -1);
    $display("[TB] dir 4, 90 degrees");
    apply_stimulus(4, 100, -1, -1, -1, 1'b0, -1);
    $display("[TB] dir 2, then back-to-back dir 2 with random stalls and stray start");
    apply_stimulus(2, 100, -1, -1, -1, 1'b0, 2);
    apply_stimulus(2, 50, -1, 100, -1, 1'b1, -1);

    $display("[TB] abort at beat 37");
    apply_stimulus(6, 80, 37, -1, -1, 1'b0, -1);

    // abort alongside start in IDLE must swallow the start
    @(negedge clk);
    start = 1'b1; abort = 1'b1; dir = 4'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_output("idle_abort_busy", int'(busy), 0);
    @(negedge clk);
    check_output("idle_abort_valid", int'(o_valid), 0);

    $display("[TB] async reset mid-scan, then clean scan");
    apply_stimulus(3, 70, -1, -1, 50, 1'b0, -1);
    apply_stimulus(3, 100, -1, -1, -1, 1'b0, -1);

    $display("[TB] random directions");
    for (int i = 0; i < 3; i++)
      apply_stimulus(int'($urandom_range(15)), int'($urandom_range(100, 30)), -1, -1, -1, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
